xsim_dma_burst_master: RTL

Burst DMA initiator for simulation builds: accepts a burst command (handle, byte address, word count, direction) and drives the single-word read-request/read-response and write32 interface of the simulation DMA memory responder. It issues one 32-bit access per cycle, returns read data on a valid/ready stream, and reports completion. It sits between a user-side memory client and the DPI-backed simulated memory.

---
 rtl/xsim_dma_pkg.sv | 26 ++
 rtl/xsim_dma_beat_counter.sv | 32 +++
 rtl/xsim_dma_burst_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/xsim_dma_pkg.sv
// Shared types and constants for the simulation burst DMA initiator.
package xsim_dma_pkg;

  // Bytes per bus word; every beat advances the address by this amount.
  localparam int unsigned WORD_BYTES = 4;

  // Width of the burst-length field and of the beat counters.
  localparam int unsigned LEN_W = 8;

  // Default largest legal burst, in words.
  localparam int unsigned MAX_BURST_DEFAULT = 16;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Next word address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/xsim_dma_beat_counter.sv
// Loadable down-counter for remaining beats, with zero / one flags.
module xsim_dma_beat_counter
  import xsim_dma_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_zero_o,
  output logic             is_one_o
);

  logic [LEN_W-1:0] count_q;

  // Load a new burst length or count one beat down; never wraps below zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!RST_N) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign is_zero_o = (count_q == '0);
  assign is_one_o  = (count_q == LEN_W'(1));

endmodule

// File: rtl/xsim_dma_burst_master.sv
// Burst DMA initiator: turns one burst command into single-word
// read-request/response or write32 accesses against the simulated memory.
module xsim_dma_burst_master
  import xsim_dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  // Command
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_handle,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  // Write data stream
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  // Read data stream
  output logic             rdata_valid,
  input  logic             rdata_ready,
  output logic [31:0]      rdata,
  output logic             rdata_last,
  // Completion
  output logic             done,
  output logic             done_error,
  // Responder read side
  output logic             en_readrequest,
  output logic [31:0]      readrequest_handle,
  output logic [31:0]      readrequest_addr,
  input  logic             rdy_readrequest,
  input  logic             rdy_readresponse,
  input  logic [31:0]      readresponse_data,
  output logic             en_readresponse,
  // Responder write side
  output logic             en_write32,
  output logic [31:0]      write32_handle,
  output logic [31:0]      write32_addr,
  output logic [31:0]      write32_data
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] handle_q;
  logic        error_q;

  logic        req_zero, req_one;
  logic        rsp_zero, rsp_one;

  logic        in_idle, in_read, in_write;
  logic        cmd_fire, cmd_bad, cmd_start;
  logic        req_fire, rsp_fire, wr_fire;

  // Decode state and the per-cycle transfer events.
  always_comb begin
    // NOTE: every signal in this block is assigned on every pass; a path
    // that skipped one would infer a latch.
    in_idle   = (state_q == ST_IDLE);
    in_read   = (state_q == ST_READ);
    in_write  = (state_q == ST_WRITE);
    cmd_fire  = in_idle && cmd_valid;
    cmd_bad   = (cmd_len == '0) || (cmd_len > MAX_LEN) || (cmd_addr[1:0] != 2'b00);
    cmd_start = cmd_fire && !cmd_bad;
    // The responder's ready already accounts for a same-cycle dequeue,
    // which is what keeps reads at one word per cycle.
    req_fire  = in_read && rdy_readrequest && !req_zero;
    // Never consume beyond the burst even if the responder misbehaves.
    rsp_fire  = in_read && rdy_readresponse && rdata_ready && !rsp_zero;
    wr_fire   = in_write && wdata_valid;
  end

  // Requests still to be issued (read) or beats still to be written.
  xsim_dma_beat_counter u_req_left (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load_i     (cmd_start),
    .load_val_i (cmd_len),
    .dec_i      (req_fire || wr_fire),
    .is_zero_o  (req_zero),
    .is_one_o   (req_one)
  );

  // Read words still to be handed to the client.
  xsim_dma_beat_counter u_rsp_left (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load_i     (cmd_start),
    .load_val_i (cmd_len),
    .dec_i      (rsp_fire),
    .is_zero_o  (rsp_zero),
    .is_one_o   (rsp_one)
  );

  // Burst controller: command capture, address walk and completion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      handle_q <= '0;
      error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            handle_q <= cmd_handle;
            addr_q   <= cmd_addr;
            if (cmd_bad) begin
              error_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= cmd_write ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (req_fire) addr_q <= next_word_addr(addr_q);
          if (rsp_fire && rsp_one) state_q <= ST_DONE;
        end
        ST_WRITE: begin
          if (wr_fire) begin
            addr_q <= next_word_addr(addr_q);
            if (req_one) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          error_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Held low during reset so the client sees no ready until reset releases.
  assign cmd_ready = RST_N && in_idle;

  assign wdata_ready = in_write;

  assign rdata_valid     = in_read && rdy_readresponse;
  assign rdata           = in_read ? readresponse_data : '0;
  assign rdata_last      = rdata_valid && rsp_one;
  assign en_readresponse = rsp_fire;

  assign en_readrequest     = req_fire;
  assign readrequest_handle = handle_q;
  assign readrequest_addr   = addr_q;

  assign en_write32     = wr_fire;
  assign write32_handle = handle_q;
  assign write32_addr   = addr_q;
  assign write32_data   = in_write ? wdata : '0;

  assign done       = (state_q == ST_DONE);
  assign done_error = done && error_q;

endmodule
